// File: rtl/sysbus_mem_responder_if.sv
// ============================================================================
// Module   : sysbus_mem_responder_if
// Brief    : System bus request/response signal bundle with requester (master)
//            and memory responder (slave) views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sysbus_mem_responder_if #(
  parameter int DW = 64,
  parameter int TW = 13
);
  logic          bus_reqcyc;
  logic          bus_reqack;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_respcyc;
  logic          bus_respack;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

`default_nettype wire

// File: rtl/sysbus_mem_responder.sv
// ============================================================================
// Module   : sysbus_mem_responder
// Brief    : Memory-side system bus target servicing line reads/writes from an
//            internal word array. Optional SYSBUS_RESP_CRITWORD_EN returns read
//            beats critical-word-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 4,
  parameter int LINE_BEATS     = 8
) (
  input  wire logic               clk,
  input  wire logic               reset,
  sysbus_mem_responder_if.slave   bus
);

  localparam int AW   = $clog2(MEM_WORDS);
  localparam int BW   = $clog2(LINE_BEATS);
  localparam int LW   = (AW > BW) ? (AW - BW) : 1;
  localparam int LATW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RWAIT = 2'd2,
    RDATA = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic [LATW-1:0]           lat_q, lat_d;
  logic [LW-1:0]             base_q, base_d;
  logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                      ack_q, ack_d;
  logic                      respcyc_q, respcyc_d;
  logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;

  logic [BUS_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  logic                      w_we;
  logic                      w_wr_en;
  logic [AW-1:0]             w_wr_idx;
  logic [BW-1:0]             w_rd_beat;
  logic [BW-1:0]             w_rd_ord;
  logic [AW-1:0]             w_rd_idx;
  logic [BUS_DATA_WIDTH-1:0] w_rd_data;

`ifdef SYSBUS_RESP_CRITWORD_EN
  logic [BW-1:0]             off_q, off_d;
  assign w_rd_ord = off_q + w_rd_beat;
`else
  assign w_rd_ord = w_rd_beat;
`endif

  // Next beat to present: beat 0 when leaving RWAIT, otherwise the following one.
  assign w_rd_beat = (state_q == RDATA) ? beat_q + 1'b1 : '0;
  assign w_rd_idx  = AW'({base_q, w_rd_ord});
  assign w_rd_data = mem_q[w_rd_idx];
  assign w_wr_idx  = AW'({base_q, beat_q});
  assign w_wr_en   = reset & w_we;

  assign bus.bus_reqack  = ack_q | w_wr_en;
  assign bus.bus_respcyc = respcyc_q;
  assign bus.bus_resp    = resp_q;
  assign bus.bus_resptag = respcyc_q ? tag_q : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      lat_q     <= '0;
      base_q    <= '0;
      tag_q     <= '0;
      ack_q     <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
`ifdef SYSBUS_RESP_CRITWORD_EN
      off_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      base_q    <= base_d;
      tag_q     <= tag_d;
      ack_q     <= ack_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
`ifdef SYSBUS_RESP_CRITWORD_EN
      off_q     <= off_d;
`endif
    end
  end

  // Array contents survive reset; only accepted write beats modify it.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[w_wr_idx] <= bus.bus_req;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    base_d    = base_q;
    tag_d     = tag_q;
    ack_d     = 1'b0;
    respcyc_d = respcyc_q;
    resp_d    = resp_q;
    w_we      = 1'b0;
`ifdef SYSBUS_RESP_CRITWORD_EN
    off_d     = off_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.bus_reqcyc) begin
          ack_d  = 1'b1;
          base_d = bus.bus_req[BW+3 +: LW];
          tag_d  = bus.bus_reqtag;
          beat_d = '0;
`ifdef SYSBUS_RESP_CRITWORD_EN
          off_d  = bus.bus_req[3 +: BW];
`endif
          if (bus.bus_reqtag[BUS_TAG_WIDTH-1]) begin
            state_d = RWAIT;
            lat_d   = LATW'(READ_LATENCY - 1);
          end else begin
            state_d = WDATA;
          end
        end
      end

      WDATA: begin
        // The address-ack cycle still carries the address, so it is not data.
        if (bus.bus_reqcyc && !ack_q) begin
          w_we   = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end

      RWAIT: begin
        if (lat_q == '0) begin
          state_d   = RDATA;
          beat_d    = '0;
          respcyc_d = 1'b1;
          resp_d    = w_rd_data;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end

      RDATA: begin
        if (bus.bus_respack) begin
          if (beat_q == LAST_BEAT) begin
            state_d   = IDLE;
            respcyc_d = 1'b0;
            resp_d    = '0;
          end else begin
            beat_d = beat_q + 1'b1;
            resp_d = w_rd_data;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
Responder (memory side) of the system bus that the core issues requests on. It accepts line-sized read and write requests and services them from an internal word array. Reads are answered with a multi-beat tagged response after a fixed latency. It is the bus-side target in standalone core simulation, and the reference model for the bus arbiter.

Parameters:
BUS_DATA_WIDTH, 64, data/address width of bus_req and bus_resp.
BUS_TAG_WIDTH, 13, tag width; bit 12 = direction (1 read, 0 write), bits 11:8 = type, bits 7:0 = id.
MEM_WORDS, 4096, depth of the internal 64-bit word array; must be a power of 2 and at least 8.
READ_LATENCY, 4, cycles from the read-address ack to the first response beat; must be at least 1.
LINE_BEATS, 8, beats per transaction (64-byte line).

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset; asserted when 0
bus_reqcyc  in  1  request valid (address phase, then write-data beats)
bus_reqack  out  1  request/beat accepted this cycle
bus_req  in  BUS_DATA_WIDTH  address (address phase) or write data (data beats)
bus_reqtag  in  BUS_TAG_WIDTH  request tag, sampled in the address phase
bus_respcyc  out  1  response beat valid
bus_respack  in  1  requester accepts the current beat
bus_resp  out  BUS_DATA_WIDTH  read data beat
bus_resptag  out  BUS_TAG_WIDTH  tag of the read being answered (copy of the request tag)

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE; bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0.
  - Beat and latency counters are cleared.
  - Memory contents are preserved.
  - Reset mid-transaction abandons it. A partially written line keeps the beats already accepted.
- Address decode:
  - Line index = addr[5:3] beat offset; word index = addr[3+log2(MEM_WORDS)-1:6] concatenated with the beat number.
  - Upper bits are ignored, so addresses wrap modulo MEM_WORDS*8 bytes.
  - addr[2:0] is ignored.
- States: IDLE, WDATA, RWAIT, RDATA.
- IDLE:
  - On bus_reqcyc=1, bus_reqack=1 for exactly that cycle (registered ack, asserted the cycle after reqcyc is first seen, one cycle wide).
  - Line base and tag are captured.
  - tag[12]=1 goes to RWAIT with the latency counter at READ_LATENCY-1; tag[12]=0 goes to WDATA with beat=0.
- WDATA:
  - Each cycle with bus_reqcyc=1 writes bus_req to word (base + beat), asserts bus_reqack that cycle, and increments beat.
  - A cycle with bus_reqcyc=0 is a bubble: no write, no ack.
  - After beat LINE_BEATS-1 is accepted, return to IDLE. No write response is issued.
- RWAIT: decrement the counter each cycle; at 0, go to RDATA with beat=0.
- RDATA:
  - bus_respcyc=1, bus_resp=mem[base+order(beat)], bus_resptag=captured tag.
  - The beat advances only on a cycle with bus_respack=1; otherwise bus_resp and bus_resptag are held stable.
  - After the last beat is acked, the next cycle has bus_respcyc=0 and the state is IDLE.
- While not in IDLE, no new address is accepted: bus_reqack=0 except for WDATA beats. The requester holds bus_reqcyc until acked.
- Read data is sampled from the array when the beat is presented. A write cannot overlap a read because there is a single outstanding transaction.
- Back-to-back: a new request may be acked on the first IDLE cycle after the previous transaction ends (one idle cycle minimum between transactions).
- order(beat) = beat unless the optional feature is enabled.

Optional Feature:
- Macro: SYSBUS_RESP_CRITWORD_EN.
- Defined: read beats are returned critical-word-first. order(beat) = (addr[5:3] + beat) mod LINE_BEATS, so the first beat is the requested word and the order wraps within the line. Writes are unaffected.
- Undefined: read beats are always returned in line order 0..7 regardless of addr[5:3].

Test Plan:
- Reset: hold reset=0 for 3 cycles with bus_reqcyc=1 -> bus_reqack, bus_respcyc, bus_resp and bus_resptag are all 0.
- Write then read:
  - Stimulus: write to addr 0x1000, tag 0x0005, beats 0x11..0x88. Then read addr 0x1000, tag 0x1005, bus_respack held at 1.
  - Required response: first bus_respcyc exactly READ_LATENCY cycles after the read ack; 8 consecutive beats 0x11..0x88; bus_resptag=0x1005 on every beat.
- Backpressure: same read with bus_respack toggling 1,0,0,1 -> each beat is held unchanged while bus_respack=0; 8 beats delivered in order with no duplicates or drops.
- Write bubbles: write to 0x2040 with bus_reqcyc low on beats 3 and 6 -> exactly 8 acks; read-back of 0x2040 matches all 8 beats.
- Critical word (SYSBUS_RESP_CRITWORD_EN defined): read 0x1028 after the 0x1000 write -> beats 0x66,0x77,0x88,0x11,...,0x55. Undefined: beats 0x11..0x88.
- Reset mid-read: reset=0 during the 3rd response beat -> bus_respcyc=0 next cycle; a following read of 0x1000 returns the full correct line.
